// File: rtl/sa_pkg.sv
// sa_pkg: state codes and size helpers shared by the systolic-array scheduler.
package sa_pkg;
   typedef logic [1:0] state_t;
   localparam state_t S_LOAD = 2'd0, S_CLEAR = 2'd1, S_FEED = 2'd2, S_OUT = 2'd3;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   function automatic int nbytes_in(input int n);
      return 2 * n * n;
   endfunction
   function automatic int feed_len(input int n);
      return 3 * n - 1;
   endfunction
   function automatic int nbytes_out(input int n, input int accw);
      return n * n * accw / 8;
   endfunction
endpackage

// File: rtl/sa_sched_if.sv
// sa_sched_if: scheduler <-> systolic array connection.
interface sa_sched_if #(parameter int N = 2, parameter int DW = 8, parameter int ACCW = 16);
   logic                              sa_clr;
   logic                              sa_en;
   logic [N*DW-1:0]                   sa_a;
   logic [N*DW-1:0]                   sa_b;
   logic [sa_pkg::idx_w(N*N)-1:0]     sa_res_sel;
   logic [ACCW-1:0]                   sa_res_i;
   modport master (output sa_clr, sa_en, sa_a, sa_b, sa_res_sel, input sa_res_i);
   modport slave  (input sa_clr, sa_en, sa_a, sa_b, sa_res_sel, output sa_res_i);
endinterface

// File: rtl/sa_skew.sv
// sa_skew: diagonal skew mux; row/column r at step t carries operand k = t - r.
module sa_skew import sa_pkg::*; #(
   parameter int N  = 2,
   parameter int DW = 8
) (
   input  logic [N*N*DW-1:0]             i_a,
   input  logic [N*N*DW-1:0]             i_b,
   input  logic [idx_w(feed_len(N))-1:0] i_t,
   output logic [N*DW-1:0]               o_a,
   output logic [N*DW-1:0]               o_b
);
   always_comb begin
      o_a = '0;
      o_b = '0;
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++)
            if (int'(i_t) == r + k) begin
               o_a[r*DW +: DW] = i_a[(r*N+k)*DW +: DW];
               o_b[r*DW +: DW] = i_b[(k*N+r)*DW +: DW];
            end
   end
endmodule

// File: rtl/sa_sched.sv
// sa_sched: loads A/B bytes, clears and feeds the array skewed, then streams
// every accumulator out little-endian on res_o.
module sa_sched import sa_pkg::*; #(
   parameter int N    = 2,
   parameter int DW   = 8,
   parameter int ACCW = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_v,
   input  logic [7:0] data_i,
   output logic [7:0] res_o,
   output logic       res_v,
   output logic       busy,
   sa_sched_if.master arr
);
   localparam int NN    = N * N;
   localparam int BPW   = ACCW / 8;
   localparam int NIN   = nbytes_in(N);
   localparam int NFEED = feed_len(N);
   localparam int NOUT  = nbytes_out(N, ACCW);
   localparam int CIW   = idx_w(NIN);
   localparam int TW    = idx_w(NFEED);
   localparam int COW   = idx_w(NOUT);
   localparam int BW    = idx_w(BPW);
   localparam int SW    = idx_w(NN);

   state_t             r_state;
   logic [CIW-1:0]     r_cnt;
   logic [TW-1:0]      r_t;
   logic [COW-1:0]     r_c;
   logic [DW-1:0]      r_ops [NIN];
   logic [7:0]         r_res_o;
   logic               r_res_v;
   logic [2*NN*DW-1:0] w_ops;
   logic [N*DW-1:0]    w_a, w_b;
   logic [BW-1:0]      w_bi;
   logic [ACCW-1:0]    w_sh;
   logic               w_feed;

   always_comb begin
      w_ops = '0;
      for (int k = 0; k < NIN; k++) w_ops[k*DW +: DW] = r_ops[k];
   end

   sa_skew #(.N(N), .DW(DW)) u_skew (
      .i_a (w_ops[0 +: NN*DW]),
      .i_b (w_ops[NN*DW +: NN*DW]),
      .i_t (r_t),
      .o_a (w_a),
      .o_b (w_b)
   );

   assign w_feed         = r_state == S_FEED;
   assign w_bi           = BW'(int'(r_c) % BPW);
   assign w_sh           = arr.sa_res_i >> {w_bi, 3'b000};
   assign arr.sa_clr     = r_state == S_CLEAR;
   assign arr.sa_en      = w_feed;
   assign arr.sa_a       = w_feed ? w_a : '0;
   assign arr.sa_b       = w_feed ? w_b : '0;
   assign arr.sa_res_sel = SW'(int'(r_c) / BPW);
   assign res_o          = r_res_o;
   assign res_v          = r_res_v;
   assign busy           = r_state != S_LOAD;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_LOAD;
         r_cnt   <= '0;
         r_t     <= '0;
         r_c     <= '0;
         r_res_o <= '0;
         r_res_v <= 1'b0;
         for (int k = 0; k < NIN; k++) r_ops[k] <= '0;
      end else begin
         r_res_v <= r_state == S_OUT;
         r_res_o <= (r_state == S_OUT) ? w_sh[7:0] : '0;
         case (r_state)
            S_LOAD: if (data_v) begin
               r_ops[r_cnt] <= DW'(data_i);
               r_cnt        <= (r_cnt == CIW'(NIN - 1)) ? '0 : r_cnt + 1'b1;
               if (r_cnt == CIW'(NIN - 1)) r_state <= S_CLEAR;
            end
            S_CLEAR: r_state <= S_FEED;
            S_FEED: begin
               r_t <= (r_t == TW'(NFEED - 1)) ? '0 : r_t + 1'b1;
               if (r_t == TW'(NFEED - 1)) r_state <= S_OUT;
            end
            default: begin
               r_c <= (r_c == COW'(NOUT - 1)) ? '0 : r_c + 1'b1;
               if (r_c == COW'(NOUT - 1)) r_state <= S_LOAD;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sa_sched.sv
// tb_sa_sched: scoreboard bench for sa_sched against a behavioural output-stationary array.
module tb_sa_sched;
   import sa_pkg::*;
   localparam int N = 2, DW = 8, ACCW = 16, BPW = ACCW / 8, NIN = 2 * N * N;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       data_v = 1'b0;
   logic [7:0] data_i = '0;
   logic [7:0] res_o;
   logic       res_v, busy;

   sa_sched_if #(.N(N), .DW(DW), .ACCW(ACCW)) ifc ();
   sa_sched #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_v (data_v),
      .data_i (data_i),
      .res_o  (res_o),
      .res_v  (res_v),
      .busy   (busy),
      .arr    (ifc)
   );

   always #5 clk = ~clk;

   int                n_chk = 0, n_err = 0, n_clr = 0;
   logic [7:0]        rq [$];
   logic [2*N*DW-1:0] fq [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // behavioural array: operands hop one cell per cycle, products are registered
   logic [DW-1:0]   ma [N][N], mb [N][N];
   logic [2*DW-1:0] mp [N][N];
   logic [ACCW-1:0] macc [N][N];
   logic [DW-1:0]   ai, bi;
   always @(posedge clk)
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (ifc.sa_clr) begin
               ma[i][j] <= '0; mb[i][j] <= '0; mp[i][j] <= '0; macc[i][j] <= '0;
            end else if (ifc.sa_en) begin
               ai = (j == 0) ? ifc.sa_a[i*DW +: DW] : ma[i][(j == 0) ? 0 : j - 1];
               bi = (i == 0) ? ifc.sa_b[j*DW +: DW] : mb[(i == 0) ? 0 : i - 1][j];
               ma[i][j]   <= ai;
               mb[i][j]   <= bi;
               mp[i][j]   <= ai * bi;
               macc[i][j] <= macc[i][j] + ACCW'(mp[i][j]);
            end
   assign ifc.sa_res_i = macc[int'(ifc.sa_res_sel) / N][int'(ifc.sa_res_sel) % N];

   always @(negedge clk) if (rst_n) begin
      if (ifc.sa_clr) n_clr++;
      if (ifc.sa_en) begin
         chk("feed_q", fq.size() > 0, 1);
         if (fq.size() > 0) chk("feed", {ifc.sa_a, ifc.sa_b}, fq.pop_front());
      end else chk("idle_ab", {ifc.sa_a, ifc.sa_b}, 0);
      if (res_v) begin
         chk("res_q", rq.size() > 0, 1);
         if (rq.size() > 0) chk("res", res_o, rq.pop_front());
      end
   end

   task automatic push_job(input logic [7:0] b [NIN]);
      logic [N*DW-1:0] ea, eb;
      logic [ACCW-1:0] v;
      int s;
      for (int t = 0; t < 3 * N - 1; t++) begin
         ea = '0; eb = '0;
         for (int r = 0; r < N; r++)
            if (t - r >= 0 && t - r < N) begin
               ea[r*DW +: DW] = b[r*N + t - r];
               eb[r*DW +: DW] = b[N*N + (t - r)*N + r];
            end
         fq.push_back({ea, eb});
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += int'(b[i*N + k]) * int'(b[N*N + k*N + j]);
            v = ACCW'(s);
            for (int m = 0; m < BPW; m++) rq.push_back(v[8*m +: 8]);
         end
   endtask

   task automatic send_job(input logic [7:0] b [NIN], input int gap);
      push_job(b);
      for (int n = 0; n < NIN; n++) begin
         chk("busy_load", busy, 0);
         data_v = 1'b1; data_i = b[n];
         @(posedge clk); #1;
         data_v = 1'b0;
         if (n < NIN - 1)
            repeat (gap) begin
               chk("busy_gap", busy, 0);
               @(posedge clk); #1;
            end
      end
      chk("busy_set", busy, 1);
   endtask

   task automatic wait_done();
      int g = 0;
      while ((rq.size() > 0 || busy) && g < 300) begin
         @(posedge clk); #1; g++;
      end
      chk("done", g < 300, 1);
      chk("fq_left", fq.size(), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {ifc.sa_clr, ifc.sa_en, ifc.sa_res_sel, res_v, busy}, 0);
      chk({tag, "_ab"}, {ifc.sa_a, ifc.sa_b}, 0);
      chk({tag, "_res"}, res_o, 0);
   endtask

   logic [7:0] j_basic [NIN] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
   logic [7:0] j_mix   [NIN] = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
   logic [7:0] j_ff    [NIN] = '{default: 8'hFF};
   logic [7:0] j_rst   [NIN] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
   logic [7:0] j_id    [NIN] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
   logic [7:0] j_b2b   [NIN] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, cnt, g;
      #2 rst_n = 1'b0;
      #1 chk_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      c0 = n_clr;
      send_job(j_basic, 0);
      wait_done();
      chk("clr_basic", n_clr - c0, 1);

      send_job(j_basic, 3);
      wait_done();

      // bytes offered while busy must be dropped; the stream that follows is an all-0xFF job
      c0 = n_clr;
      send_job(j_mix, 0);
      push_job(j_ff);
      data_v = 1'b1; data_i = 8'hFF;
      cnt = 0; g = 0;
      while (cnt < NIN && g < 300) begin
         if (!busy) begin
            if (cnt == 0) chk("overlap_res_v", res_v, 1);
            cnt++;
         end
         @(posedge clk); #1; g++;
      end
      data_v = 1'b0;
      chk("ff_accept", cnt, NIN);
      wait_done();
      chk("clr_ff", n_clr - c0, 2);

      send_job(j_rst, 0);
      g = 0;
      while (!ifc.sa_en && g < 50) begin
         @(posedge clk); #1; g++;
      end
      repeat (2) @(posedge clk);
      #1 chk("rst_at_feed", ifc.sa_en, 1);
      rst_n = 1'b0;
      #1 chk_zero("mid_rst");
      rq.delete();
      fq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      c0 = n_clr;
      send_job(j_id, 0);
      wait_done();
      chk("clr_id", n_clr - c0, 1);

      c0 = n_clr;
      send_job(j_b2b, 0);
      g = 0;
      while (!res_v && g < 100) begin
         @(posedge clk); #1; g++;
      end
      while (res_v && g < 100) begin
         @(posedge clk); #1; g++;
      end
      chk("b2b_wait", g < 100, 1);
      send_job(j_mix, 0);
      wait_done();
      chk("clr_b2b", n_clr - c0, 2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/sa_sched.md
Name: sa_sched

Overview:
- Job sequencer for the N x N output-stationary systolic array inside tt_um_essen.
- Collects the A and B operand bytes from the pad inputs, clears the array, and feeds it with diagonally skewed rows and columns.
- Then reads back every accumulator and streams it out byte-serially on uo_out, with result_v on uio_out[7].
- Sits between the top-level pad mux and the array instance; the DFT/JTAG path (tck) is independent of this block.

Parameters:
- N, 2, array dimension; must be 2..4.
- DW, 8, operand width in bits.
- ACCW, 16, accumulator width in bits; must be a multiple of 8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_v  in  1  operand byte valid.
- data_i  in  8  operand byte.
- sa_clr  out  1  one-cycle pulse that clears all array accumulators.
- sa_en  out  1  array advance enable.
- sa_a  out  N*DW  left-edge row inputs; row i is at [i*DW +: DW].
- sa_b  out  N*DW  top-edge column inputs; column j is at [j*DW +: DW].
- sa_res_sel  out  $clog2(N*N)  accumulator read index, k = i*N+j.
- sa_res_i  in  ACCW  accumulator value selected by sa_res_sel (combinational inside the array).
- res_o  out  8  result byte.
- res_v  out  1  result byte valid (drives uio_out[7]).
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset: the async assert forces state=LOAD and clears all counters and operand registers. All outputs reset to 0.
- Reset mid-job: the job is discarded, with no partial output. The next byte after release is A[0][0].
- States: LOAD -> CLEAR -> FEED -> OUT -> LOAD.
- LOAD:
  - Each cycle with data_v=1 stores data_i and increments the byte counter.
  - Byte order: A row-major (N*N bytes), then B row-major (N*N bytes).
  - On the 2*N*N-th byte, go to CLEAR next cycle. The counter resets to 0.
  - data_v is ignored in all other states; those bytes are dropped, not queued.
- CLEAR: one cycle. sa_clr=1, sa_en=0, sa_a=sa_b=0.
- FEED: 3N-1 cycles, t=0..3N-2, with sa_en=1.
  - sa_a row i = A[i][t-i] when 0<=t-i<N, else 0.
  - sa_b column j = B[t-j][j] when 0<=t-j<N, else 0.
  - The last cycle (t=3N-2) is always all-zero and flushes the final MAC register.
  - After t=3N-2, go to OUT.
- Outputs in non-FEED states: sa_en=0 and sa_a=sa_b=0. sa_clr=0 outside CLEAR.
- OUT:
  - Runs for N*N*(ACCW/8) cycles, c=0..N*N*ACCW/8-1.
  - sa_res_sel = c / (ACCW/8); byte index b = c mod (ACCW/8).
  - res_o and res_v are registered. res_o <= sa_res_i[8b +: 8] (little-endian), and res_v <= 1, one cycle after the index is issued.
  - The result stream is therefore contiguous: res_v is high for exactly N*N*ACCW/8 consecutive cycles, starting the cycle after OUT is entered.
  - After the last c, go to LOAD. res_v drops to 0 the following cycle.
- busy: combinational, !(state==LOAD).
- Ordering guarantee: the first byte of the next job can be accepted in the cycle res_v is still presenting the final byte. There is no overlap hazard, because the operand registers are only read in FEED.
- Arithmetic: no arithmetic in this block. Accumulator overflow is the array's concern; result bytes are passed through verbatim.
- Counters: each counter is sized for its own maximum and wraps to 0 on every state exit.

Decomposition:
- Shared package sa_pkg holds:
  - the state enum (LOAD, CLEAR, FEED, OUT);
  - derived constants NBYTES_IN=2*N*N, FEED_LEN=3N-1, NBYTES_OUT=N*N*ACCW/8;
  - the index-width function.
- One natural sub-module: sa_skew, the combinational skew mux.
  - Inputs: the A and B operand arrays plus t.
  - Outputs: sa_a and sa_b.
  - Kept separate so it can be reused by the array's DFT pattern generator.

Test Plan (N=2, DW=8, ACCW=16, bench uses a behavioural array model):
- Basic multiply:
  - Stimulus: stream 1,2,3,4,5,6,7,8.
  - FEED must show t0 a=[1,0] b=[5,0]; t1 a=[2,3] b=[7,6]; t2 a=[0,4] b=[0,8]; t3/t4 all zero.
  - res_o must be 0x13,0x00,0x16,0x00,0x2B,0x00,0x32,0x00 over 8 consecutive res_v cycles.
- Gapped input: the same bytes with data_v low for 3 cycles between each byte -> identical FEED sequence and identical results. busy stays 0 until the 8th byte.
- Busy drop: hold data_v=1 with 0xFF throughout CLEAR/FEED/OUT -> no effect on results. The first byte accepted is in the cycle after OUT completes.
- Reset mid-FEED: assert rst_n low at t=2 -> all outputs 0 immediately. A following job with A=identity, B=9,8,7,6 yields 9,0,8,0,7,0,6,0.
- Back-to-back jobs: start the second job's bytes the cycle res_v drops -> both result streams correct. Exactly one sa_clr pulse per job.
- Full-scale values: all operands 0xFF -> model sum 0x1FC02 truncates to 0xFC02. Each element outputs 0x02,0xFC.
